// File: rtl/pio_poll_pkg.sv
// Shared definitions for the PIO polling master: FSM state encoding and
// the widths of the poll timer and the debounce counter.
package pio_poll_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        LAT  = 2'd2
    } poll_state_e;

    localparam int TIMER_W  = 16;
    localparam int DB_CNT_W = 4;

endpackage : pio_poll_pkg

// File: rtl/pio_debounce.sv
// Debounce and edge detection for the polled PIO bit.
// Configuration macro: PIO_POLL_DEBOUNCE_EN
//   defined   : level_o toggles after DB_COUNT consecutive samples that
//               differ from it; any agreeing sample clears the count.
//   undefined : every differing sample toggles level_o immediately.
// rise_o/fall_o are single-cycle pulses registered together with level_o.
module pio_debounce
    import pio_poll_pkg::*;
#(
    parameter int DB_COUNT = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sample_valid_i,
    input  logic sample_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic level_q, level_d;
    logic rise_q,  rise_d;
    logic fall_q,  fall_d;

`ifdef PIO_POLL_DEBOUNCE_EN
    localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DB_COUNT - 1);

    logic [DB_CNT_W-1:0] cnt_q, cnt_d;

    // Next-state for the counter, level and edge pulses (debounced build).
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_valid_i) begin
            if (sample_i == level_q) begin
                cnt_d = {DB_CNT_W{1'b0}};
            end else if (cnt_q >= DB_LAST) begin
                // Run of differing samples complete: commit the new level.
                cnt_d   = {DB_CNT_W{1'b0}};
                level_d = sample_i;
                rise_d  = sample_i;
                fall_d  = ~sample_i;
            end else begin
                cnt_d = cnt_q + DB_CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Debounce counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= {DB_CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    // Next-state for level and edge pulses (immediate-follow build).
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sample_valid_i && (sample_i != level_q)) begin
            level_d = sample_i;
            rise_d  = sample_i;
            fall_d  = ~sample_i;
        end else begin
            level_d = level_q;
        end
    end
`endif

    // Level and edge pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule : pio_debounce

// File: rtl/pio_poll_master.sv
// Avalon-MM polling master: every POLL_DIV enabled idle cycles it issues a
// single read of POLL_ADDR, captures bit 0 of the returned word one cycle
// after the read is accepted and hands it to the debouncer.
// Configuration macro: PIO_POLL_DEBOUNCE_EN (see pio_debounce).
module pio_poll_master
    import pio_poll_pkg::*;
#(
    parameter int         POLL_DIV  = 1000,
    parameter int         DB_COUNT  = 4,
    parameter logic [1:0] POLL_ADDR = 2'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    output logic [1:0]  avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        level_o,
    output logic        rise_o,
    output logic        fall_o,
    output logic        busy_o
);

    localparam logic [TIMER_W-1:0] TIMER_RELOAD = TIMER_W'(POLL_DIV - 1);

    // Reject out-of-range configurations at elaboration time.
    if ((POLL_DIV < 2) || (POLL_DIV > 65535)) begin : g_bad_poll_div
        $error("pio_poll_master: POLL_DIV out of range 2..65535");
    end
    if ((DB_COUNT < 1) || (DB_COUNT > 15)) begin : g_bad_db_count
        $error("pio_poll_master: DB_COUNT out of range 1..15");
    end

    poll_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               avm_read_q;
    logic               busy_q;
    logic               sample_valid_s;
    logic               unused_rdata_s;

    // Next-state logic for the poll FSM and the poll interval timer.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (timer_q == {TIMER_W{1'b0}}) begin
                        state_d = REQ;
                        timer_d = TIMER_RELOAD;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end else begin
                    timer_d = timer_q;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    state_d = LAT;
                end else begin
                    state_d = REQ;
                end
            end
            LAT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                timer_d = TIMER_RELOAD;
            end
        endcase
    end

    // State, timer and registered bus/busy outputs decoded from next state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            timer_q    <= TIMER_RELOAD;
            avm_read_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            avm_read_q <= (state_d == REQ);
            busy_q     <= (state_d != IDLE);
        end
    end

    // The read data is only meaningful during the latency cycle; outside it
    // (including a reply to a read abandoned by reset) it is ignored.
    assign sample_valid_s = (state_q == LAT);
    assign unused_rdata_s = ^avm_readdata[31:1];

    assign avm_address = POLL_ADDR;
    assign avm_read    = avm_read_q;
    assign busy_o      = busy_q;

    pio_debounce #(
        .DB_COUNT (DB_COUNT)
    ) u_debounce (
        .clk            (clk),
        .reset_n        (reset_n),
        .sample_valid_i (sample_valid_s),
        .sample_i       (avm_readdata[0]),
        .level_o        (level_o),
        .rise_o         (rise_o),
        .fall_o         (fall_o)
    );

endmodule : pio_poll_master

// File: tb/tb_pio_poll_master.sv
// Randomized self-checking bench for pio_poll_master. A transaction-level
// reference (idle-cycle count to the next poll, streak of differing samples)
// predicts every output each cycle.
module tb_pio_poll_master;

    localparam int POLL_DIV = 4;
    localparam int DB_COUNT = 3;
`ifdef PIO_POLL_DEBOUNCE_EN
    localparam int DB_EFF = DB_COUNT;
`else
    localparam int DB_EFF = 1;
`endif
    localparam int N_CYCLES = 2000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        level_o, rise_o, fall_o, busy_o;

    pio_poll_master #(
        .POLL_DIV  (POLL_DIV),
        .DB_COUNT  (DB_COUNT),
        .POLL_ADDR (2'd0)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .enable          (enable),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_waitrequest (avm_waitrequest),
        .avm_readdata    (avm_readdata),
        .level_o         (level_o),
        .rise_o          (rise_o),
        .fall_o          (fall_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    int checks_cnt = 0;
    int errors_cnt = 0;

    // Reference model state
    bit m_read, m_lat, m_level, m_rise, m_fall;
    int m_idle_cnt, m_streak;
    int n_rise, n_fall, n_polls;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_read = 0; m_lat = 0; m_level = 0; m_rise = 0; m_fall = 0;
        m_idle_cnt = 0; m_streak = 0;
    endtask

    // Advance the reference by one clock edge given the inputs seen at it.
    task automatic model_step(input bit en, input bit wr, input bit rd);
        m_rise = 0;
        m_fall = 0;
        if (m_lat) begin
            m_lat = 0;
            n_polls++;
            if (rd == m_level) m_streak = 0;
            else               m_streak++;
            if (m_streak >= DB_EFF) begin
                m_level  = rd;
                m_rise   = rd;
                m_fall   = !rd;
                m_streak = 0;
            end
        end else if (m_read) begin
            if (!wr) begin
                m_read = 0;
                m_lat  = 1;
            end
        end else if (en) begin
            if (m_idle_cnt == POLL_DIV - 1) begin
                m_read     = 1;
                m_idle_cnt = 0;
            end else begin
                m_idle_cnt++;
            end
        end
    endtask

    task automatic compare_all(input string when);
        check_eq({when, "_read"},  {31'd0, avm_read}, {31'd0, m_read});
        check_eq({when, "_addr"},  {30'd0, avm_address}, 32'd0);
        check_eq({when, "_busy"},  {31'd0, busy_o},   {31'd0, (m_read | m_lat)});
        check_eq({when, "_level"}, {31'd0, level_o},  {31'd0, m_level});
        check_eq({when, "_rise"},  {31'd0, rise_o},   {31'd0, m_rise});
        check_eq({when, "_fall"},  {31'd0, fall_o},   {31'd0, m_fall});
    endtask

    initial begin
        bit rd_bit, did_rst;
        rd_bit  = 0;
        did_rst = 0;
        n_rise = 0; n_fall = 0; n_polls = 0;
        model_reset();
        repeat (3) @(negedge clk);
        compare_all("reset");
        reset_n = 1'b1;
        enable  = 1'b1;
        model_step(1'b1, 1'b0, 1'b0);

        for (int i = 0; i < N_CYCLES; i++) begin
            @(negedge clk);
            compare_all("run");
            if (m_rise) n_rise++;
            if (m_fall) n_fall++;

            // Reset pulse while a read is outstanding: outputs drop at once.
            if (!did_rst && (i >= 300) && m_read) begin
                did_rst = 1;
                reset_n = 1'b0;
                #1;
                model_reset();
                compare_all("midrst");
                @(negedge clk);
                compare_all("inrst");
                reset_n = 1'b1;
            end

            if ($urandom_range(0, 15) == 0) rd_bit = !rd_bit;
            enable          = ($urandom_range(0, 7) != 0);
            avm_waitrequest = ($urandom_range(0, 1) == 1);
            avm_readdata    = {$urandom() & 32'hFFFF_FFFE} | {31'd0, rd_bit};
            model_step(enable, avm_waitrequest, rd_bit);
        end

        @(negedge clk);
        compare_all("final");
        check_eq("mid_req_reset_done", {31'd0, did_rst}, 32'd1);
        check_eq("saw_rise", {31'd0, (n_rise > 0)}, 32'd1);
        check_eq("saw_fall", {31'd0, (n_fall > 0)}, 32'd1);
        check_eq("saw_polls", {31'd0, (n_polls > 50)}, 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule : tb_pio_poll_master
